// File: rtl/axi_lite_arbiter_if.sv
// AXI-lite bundle used on both sides of the arbiter.
// N lanes share rdata/rresp/bresp; all other signals are per-lane.
interface axi_lite_arbiter_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N-1:0]          arvalid;
    logic [N*ADDR_W-1:0]   araddr;
    logic [N-1:0]          arready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic [N-1:0]          rvalid;
    logic [N-1:0]          rready;
    logic [N-1:0]          awvalid;
    logic [N*ADDR_W-1:0]   awaddr;
    logic [N-1:0]          awready;
    logic [N-1:0]          wvalid;
    logic [N*DATA_W-1:0]   wdata;
    logic [N*DATA_W/8-1:0] wstrb;
    logic [N-1:0]          wready;
    logic [1:0]            bresp;
    logic [N-1:0]          bvalid;
    logic [N-1:0]          bready;

    modport master (
        output arvalid, araddr, rready,
        output awvalid, awaddr, wvalid, wdata, wstrb,
        output bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  arvalid, araddr, rready,
        input  awvalid, awaddr, wvalid, wdata, wstrb,
        input  bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter: NUM_M AXI-lite masters (0=IFU, 1=LSU) onto one slave.
// Ports: clk, rst (sync, active-high), m_bus (NUM_M lanes), s_bus (1 lane).
module axi_lite_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    axi_lite_arbiter_if.slave  m_bus,
    axi_lite_arbiter_if.master s_bus
);
    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_q, rr_d;
    logic [GW-1:0]     win_idx, grant_inc;
    logic              win_valid, win_wr;
    logic [NUM_M-1:0]  req, win_oh;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    int                pick_idx;

    logic s_arvalid, s_awvalid, s_wvalid;
    logic s_rready, s_bready;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [NUM_M-1:0] m_arready, m_awready, m_wready;
    logic [NUM_M-1:0] m_rvalid, m_bvalid;

    // A write competes only once AW and W are both presented.
    assign req = m_bus.arvalid | (m_bus.awvalid & m_bus.wvalid);

    // First requester at or after rr_q, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        pick_idx  = 0;
        for (int k = 0; k < NUM_M; k++) begin
            pick_idx = int'(rr_q) + k;
            if (pick_idx >= NUM_M) pick_idx = pick_idx - NUM_M;
            if (!win_valid && req[pick_idx]) begin
                win_valid = 1'b1;
                win_idx   = GW'(pick_idx);
            end
        end
    end

    // Write beats read when the winner offers both.
    assign win_wr = m_bus.awvalid[win_idx] & m_bus.wvalid[win_idx];
    assign win_oh = win_valid ? (NUM_M'(1) << win_idx) : '0;

    assign grant_inc = (int'(grant_q) == NUM_M - 1) ? '0
                                                    : grant_q + 1'b1;

    assign s_arvalid = (state_q == RD_ADDR);
    assign s_awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign s_wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign s_rready  = (state_q == RD_DATA) && m_bus.rready[grant_q];
    assign s_bready  = (state_q == WR_RESP) && m_bus.bready[grant_q];

    assign ar_hs = s_arvalid & s_bus.arready[0];
    assign r_hs  = s_rready & s_bus.rvalid[0];
    assign aw_hs = s_awvalid & s_bus.awready[0];
    assign w_hs  = s_wvalid & s_bus.wready[0];
    assign b_hs  = s_bready & s_bus.bvalid[0];

    always_comb begin
        m_arready = '0;
        m_awready = '0;
        m_wready  = '0;
        m_rvalid  = '0;
        m_bvalid  = '0;
        if (state_q == IDLE && win_valid) begin
            if (win_wr) begin
                m_awready = win_oh;
                m_wready  = win_oh;
            end else begin
                m_arready = win_oh;
            end
        end
        if (state_q == RD_DATA) m_rvalid[grant_q] = s_bus.rvalid[0];
        if (state_q == WR_RESP) m_bvalid[grant_q] = s_bus.bvalid[0];
    end

    assign m_bus.arready = m_arready;
    assign m_bus.awready = m_awready;
    assign m_bus.wready  = m_wready;
    assign m_bus.rvalid  = m_rvalid;
    assign m_bus.bvalid  = m_bvalid;
    assign m_bus.rdata   = s_bus.rdata;
    assign m_bus.rresp   = s_bus.rresp;
    assign m_bus.bresp   = s_bus.bresp;

    assign s_bus.arvalid = s_arvalid;
    assign s_bus.araddr  = addr_q;
    assign s_bus.awvalid = s_awvalid;
    assign s_bus.awaddr  = addr_q;
    assign s_bus.wvalid  = s_wvalid;
    assign s_bus.wdata   = wdata_q;
    assign s_bus.wstrb   = wstrb_q;
    assign s_bus.rready  = s_rready;
    assign s_bus.bready  = s_bready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win_idx;
                    if (win_wr) begin
                        addr_d  = m_bus.awaddr[win_idx*ADDR_W +: ADDR_W];
                        wdata_d = m_bus.wdata[win_idx*DATA_W +: DATA_W];
                        wstrb_d = m_bus.wstrb[win_idx*SW +: SW];
                        state_d = WR_REQ;
                    end else begin
                        addr_d  = m_bus.araddr[win_idx*ADDR_W +: ADDR_W];
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (ar_hs) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_d = IDLE;
                    rr_d    = grant_inc;
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // AW and W may finish in different cycles.
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                    rr_d    = grant_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a simple behavioural slave.
// Inputs change 1ns after posedge; outputs are sampled 2ns after posedge.
module tb_axi_lite_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter_if #(.N(2), .ADDR_W(32), .DATA_W(32)) m_bus ();
    axi_lite_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) s_bus ();

    axi_lite_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .m_bus (m_bus),
        .s_bus (s_bus)
    );

    logic [31:0] slv_rdata = 32'h0;
    logic [1:0]  slv_rresp = 2'b00;
    logic [1:0]  slv_bresp = 2'b00;
    bit sl_rs, sl_ar, sl_r, sl_aw, sl_w, sl_b;
    bit aw_got, w_got;

    // Slave: R one cycle after AR, B once both AW and W were taken.
    initial begin
        s_bus.rvalid = 1'b0;
        s_bus.bvalid = 1'b0;
        s_bus.rdata  = '0;
        s_bus.rresp  = '0;
        s_bus.bresp  = '0;
        forever begin
            @(negedge clk);
            sl_rs = rst;
            sl_ar = s_bus.arvalid[0] && s_bus.arready[0];
            sl_r  = s_bus.rvalid[0] && s_bus.rready[0];
            sl_aw = s_bus.awvalid[0] && s_bus.awready[0];
            sl_w  = s_bus.wvalid[0] && s_bus.wready[0];
            sl_b  = s_bus.bvalid[0] && s_bus.bready[0];
            @(posedge clk);
            #1;
            if (sl_rs) begin
                s_bus.rvalid = 1'b0;
                s_bus.bvalid = 1'b0;
                aw_got = 1'b0;
                w_got  = 1'b0;
            end else begin
                if (sl_r) s_bus.rvalid = 1'b0;
                if (sl_ar) begin
                    s_bus.rvalid = 1'b1;
                    s_bus.rdata  = slv_rdata;
                    s_bus.rresp  = slv_rresp;
                end
                if (sl_b)  s_bus.bvalid = 1'b0;
                if (sl_aw) aw_got = 1'b1;
                if (sl_w)  w_got  = 1'b1;
                if (aw_got && w_got) begin
                    s_bus.bvalid = 1'b1;
                    s_bus.bresp  = slv_bresp;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        m_bus.arvalid = '0;
        m_bus.awvalid = '0;
        m_bus.wvalid  = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Waits for an arready pulse; returns lane (-1 on timeout, 2 if bad).
    task automatic wait_ar_grant(input bit drop, output int idx);
        idx = -1;
        for (int c = 0; c < 20; c++) begin
            if (m_bus.arready == 2'b01)      idx = 0;
            else if (m_bus.arready == 2'b10) idx = 1;
            else if (m_bus.arready != 2'b00) idx = 2;
            if (idx >= 0) break;
            tick;
            #1;
        end
        if (idx >= 0) begin
            tick;
            if (drop && idx < 2) m_bus.arvalid[idx] = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        checks++;
        if ({m_bus.arready, m_bus.awready, m_bus.wready} !== 6'b0) begin
            errors++;
            $display("FAIL rst_m_ready: got %b want 0",
                     {m_bus.arready, m_bus.awready, m_bus.wready});
        end
        checks++;
        if ({m_bus.rvalid, m_bus.bvalid} !== 4'b0) begin
            errors++;
            $display("FAIL rst_m_valid: got %b want 0",
                     {m_bus.rvalid, m_bus.bvalid});
        end
        checks++;
        if ({s_bus.arvalid, s_bus.awvalid, s_bus.wvalid,
             s_bus.rready, s_bus.bready} !== 5'b0) begin
            errors++;
            $display("FAIL rst_s_ctl: got %b want 0",
                     {s_bus.arvalid, s_bus.awvalid, s_bus.wvalid,
                      s_bus.rready, s_bus.bready});
        end
        checks++;
        if ({s_bus.araddr, s_bus.wdata, s_bus.wstrb} !== 68'h0) begin
            errors++;
            $display("FAIL rst_latched: got %h want 0",
                     {s_bus.araddr, s_bus.wdata, s_bus.wstrb});
        end
    endtask

    task automatic test_single_read;
        tick;
        m_bus.arvalid = 2'b10;
        m_bus.araddr[63:32] = 32'h8000_0010;
        slv_rdata = 32'hDEAD_BEEF;
        slv_rresp = 2'b00;
        #1;
        checks++;
        if (m_bus.arready !== 2'b10) begin
            errors++;
            $display("FAIL rd_arready: got %b want 10", m_bus.arready);
        end
        tick;
        m_bus.arvalid = 2'b00;
        #1;
        checks++;
        if (s_bus.arvalid !== 1'b1 || s_bus.araddr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL rd_s_ar: got v=%b a=%h want v=1 a=80000010",
                     s_bus.arvalid, s_bus.araddr);
        end
        checks++;
        if (m_bus.rvalid !== 2'b00 || m_bus.arready !== 2'b00) begin
            errors++;
            $display("FAIL rd_addr_phase: got rv=%b ar=%b want 00 00",
                     m_bus.rvalid, m_bus.arready);
        end
        tick;
        #1;
        checks++;
        if (m_bus.rvalid !== 2'b10 || m_bus.rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_data: got rv=%b d=%h want 10 deadbeef",
                     m_bus.rvalid, m_bus.rdata);
        end
        checks++;
        if (s_bus.rready !== 1'b1) begin
            errors++;
            $display("FAIL rd_rready: got %b want 1", s_bus.rready);
        end
        tick;
        #1;
        checks++;
        if (m_bus.rvalid !== 2'b00 || s_bus.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: got rv=%b sav=%b want 00 0",
                     m_bus.rvalid, s_bus.arvalid);
        end
    endtask

    task automatic test_contention;
        int g;
        logic [31:0] ea;
        do_reset;
        m_bus.araddr  = {32'h8000_2000, 32'h8000_1000};
        m_bus.arvalid = 2'b11;
        slv_rdata = 32'h1111_0000;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_ar_grant(1'b0, g);
            ea = (k % 2 == 1) ? 32'h8000_2000 : 32'h8000_1000;
            checks++;
            if (g !== k % 2) begin
                errors++;
                $display("FAIL rr_grant%0d: got %0d want %0d", k, g, k % 2);
            end
            checks++;
            if (s_bus.araddr !== ea) begin
                errors++;
                $display("FAIL rr_addr%0d: got %h want %h",
                         k, s_bus.araddr, ea);
            end
        end
        m_bus.arvalid = 2'b00;
        tick;
        tick;
        tick;
        #1;
    endtask

    task automatic test_write;
        tick;
        m_bus.awvalid = 2'b10;
        m_bus.wvalid  = 2'b10;
        m_bus.awaddr[63:32] = 32'h8000_0100;
        m_bus.wdata[63:32]  = 32'h1234_5678;
        m_bus.wstrb[7:4]    = 4'b0011;
        s_bus.wready = 1'b0;
        slv_bresp = 2'b00;
        #1;
        checks++;
        if ({m_bus.awready, m_bus.wready} !== 4'b1010 ||
            m_bus.arready !== 2'b00) begin
            errors++;
            $display("FAIL wr_grant: got aw=%b w=%b ar=%b want 10 10 00",
                     m_bus.awready, m_bus.wready, m_bus.arready);
        end
        tick;
        m_bus.awvalid = 2'b00;
        m_bus.wvalid  = 2'b00;
        #1;
        checks++;
        if (s_bus.awvalid !== 1'b1 || s_bus.wvalid !== 1'b1) begin
            errors++;
            $display("FAIL wr_s_valid: got aw=%b w=%b want 1 1",
                     s_bus.awvalid, s_bus.wvalid);
        end
        checks++;
        if (s_bus.awaddr !== 32'h8000_0100 ||
            s_bus.wdata !== 32'h1234_5678 || s_bus.wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL wr_payload: got %h %h %b want 80000100 12345678 0011",
                     s_bus.awaddr, s_bus.wdata, s_bus.wstrb);
        end
        for (int d = 0; d < 3; d++) begin
            tick;
            #1;
            checks++;
            if (s_bus.awvalid !== 1'b0 || s_bus.wvalid !== 1'b1) begin
                errors++;
                $display("FAIL wr_hold%0d: got aw=%b w=%b want 0 1",
                         d, s_bus.awvalid, s_bus.wvalid);
            end
        end
        s_bus.wready = 1'b1;
        tick;
        #1;
        checks++;
        if (m_bus.bvalid !== 2'b10 || m_bus.bresp !== 2'b00 ||
            s_bus.bready !== 1'b1) begin
            errors++;
            $display("FAIL wr_b: got bv=%b br=%b sbr=%b want 10 00 1",
                     m_bus.bvalid, m_bus.bresp, s_bus.bready);
        end
        checks++;
        if (s_bus.wvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_w_drop: got %b want 0", s_bus.wvalid);
        end
        for (int d = 0; d < 2; d++) begin
            tick;
            #1;
            checks++;
            if (m_bus.bvalid !== 2'b00) begin
                errors++;
                $display("FAIL wr_single_b%0d: got %b want 00",
                         d, m_bus.bvalid);
            end
        end
    endtask

    task automatic test_priority;
        int g;
        do_reset;
        m_bus.awvalid = 2'b10;
        m_bus.wvalid  = 2'b10;
        m_bus.arvalid = 2'b10;
        m_bus.awaddr[63:32] = 32'h8000_0200;
        m_bus.araddr[63:32] = 32'h8000_0300;
        #1;
        checks++;
        if (m_bus.awready !== 2'b10 || m_bus.arready !== 2'b00) begin
            errors++;
            $display("FAIL pri_write_first: got aw=%b ar=%b want 10 00",
                     m_bus.awready, m_bus.arready);
        end
        tick;
        m_bus.awvalid = 2'b00;
        m_bus.wvalid  = 2'b00;
        m_bus.arvalid[0]    = 1'b1;
        m_bus.araddr[31:0]  = 32'h8000_0400;
        #1;
        wait_ar_grant(1'b1, g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL pri_m0_next: got %0d want 0", g);
        end
        wait_ar_grant(1'b1, g);
        checks++;
        if (g !== 1 || s_bus.araddr !== 32'h8000_0300) begin
            errors++;
            $display("FAIL pri_m1_read: got %0d %h want 1 80000300",
                     g, s_bus.araddr);
        end
        tick;
        tick;
        tick;
        #1;
    endtask

    task automatic test_backpressure;
        int g;
        m_bus.rready = 2'b10;
        m_bus.arvalid = 2'b01;
        m_bus.araddr[31:0] = 32'h8000_0500;
        slv_rdata = 32'hCAFE_F00D;
        slv_rresp = 2'b10;
        #1;
        wait_ar_grant(1'b1, g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL bp_grant: got %0d want 0", g);
        end
        tick;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (s_bus.rready !== 1'b0) begin
                errors++;
                $display("FAIL bp_rready%0d: got %b want 0",
                         c, s_bus.rready);
            end
            checks++;
            if (m_bus.rvalid !== 2'b01 || m_bus.rdata !== 32'hCAFE_F00D ||
                m_bus.rresp !== 2'b10) begin
                errors++;
                $display("FAIL bp_fwd%0d: got %b %h %b want 01 cafef00d 10",
                         c, m_bus.rvalid, m_bus.rdata, m_bus.rresp);
            end
            if (c < 4) begin
                tick;
                #1;
            end
        end
        m_bus.rready = 2'b11;
        #1;
        checks++;
        if (s_bus.rready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got %b want 1", s_bus.rready);
        end
        tick;
        #1;
        checks++;
        if (m_bus.rvalid !== 2'b00) begin
            errors++;
            $display("FAIL bp_done: got %b want 00", m_bus.rvalid);
        end
        slv_rresp = 2'b00;
    endtask

    task automatic test_reset_mid;
        int g;
        m_bus.rready  = 2'b01;
        m_bus.arvalid = 2'b10;
        #1;
        wait_ar_grant(1'b1, g);
        checks++;
        if (g !== 1) begin
            errors++;
            $display("FAIL mid_grant: got %0d want 1", g);
        end
        tick;
        #1;
        checks++;
        if (m_bus.rvalid !== 2'b10) begin
            errors++;
            $display("FAIL mid_stall: got %b want 10", m_bus.rvalid);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if ({m_bus.arready, m_bus.awready, m_bus.wready,
             m_bus.rvalid, m_bus.bvalid} !== 10'b0) begin
            errors++;
            $display("FAIL mid_m_idle: got %b want 0",
                     {m_bus.arready, m_bus.awready, m_bus.wready,
                      m_bus.rvalid, m_bus.bvalid});
        end
        checks++;
        if ({s_bus.arvalid, s_bus.awvalid, s_bus.wvalid,
             s_bus.rready, s_bus.bready} !== 5'b0) begin
            errors++;
            $display("FAIL mid_s_idle: got %b want 0",
                     {s_bus.arvalid, s_bus.awvalid, s_bus.wvalid,
                      s_bus.rready, s_bus.bready});
        end
        m_bus.rready  = 2'b11;
        m_bus.araddr  = {32'h8000_0700, 32'h8000_0600};
        m_bus.arvalid = 2'b11;
        #1;
        checks++;
        if (m_bus.arready !== 2'b01) begin
            errors++;
            $display("FAIL mid_ptr_reset: got %b want 01", m_bus.arready);
        end
        wait_ar_grant(1'b1, g);
        wait_ar_grant(1'b1, g);
        checks++;
        if (g !== 1 || s_bus.araddr !== 32'h8000_0700) begin
            errors++;
            $display("FAIL mid_m1_served: got %0d %h want 1 80000700",
                     g, s_bus.araddr);
        end
        tick;
        tick;
        tick;
        #1;
    endtask

    initial begin
        m_bus.arvalid = '0;
        m_bus.araddr  = '0;
        m_bus.awvalid = '0;
        m_bus.awaddr  = '0;
        m_bus.wvalid  = '0;
        m_bus.wdata   = '0;
        m_bus.wstrb   = '0;
        m_bus.rready  = 2'b11;
        m_bus.bready  = 2'b11;
        s_bus.arready = 1'b1;
        s_bus.awready = 1'b1;
        s_bus.wready  = 1'b1;
        test_reset;
        test_single_read;
        test_contention;
        test_write;
        test_priority;
        test_backpressure;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
